// File: rtl/ysyx_220066_mem_pkg.sv
// Shared types and constants for the pmem arbiter: FSM states, transaction
// owner and the full-doubleword write mask.
package ysyx_220066_mem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RREQ  = 3'd1,
      RWAIT = 3'd2,
      WREQ  = 3'd3,
      WWAIT = 3'd4,
      DONE  = 3'd5
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam logic [7:0] FULL_MASK = 8'hFF;

endpackage

// File: rtl/ysyx_220066_byte_merge.sv
// Per-byte select between an old doubleword and new store data; bytes whose
// mask bit is set take the new value.
module ysyx_220066_byte_merge (
   input  logic [63:0] old_i,
   input  logic [63:0] new_i,
   input  logic [7:0]  mask_i,
   output logic [63:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < 8; i++) begin
         if (mask_i[i]) begin
            merged_o[i*8 +: 8] = new_i[i*8 +: 8];
         end else begin
            merged_o[i*8 +: 8] = old_i[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Arbitrates the single 64-bit pmem port between IF and LSU; partial stores
// are performed as read-modify-write of the aligned doubleword.
module ysyx_220066_mem_arbiter
   import ysyx_220066_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [63:0] if_rdata_o,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [63:0] lsu_addr_i,
   input  logic [63:0] lsu_wdata_i,
   input  logic [7:0]  lsu_wmask_i,
   output logic        lsu_gnt_o,
   output logic        lsu_rvalid_o,
   output logic [63:0] lsu_rdata_o,
   output logic        lsu_wdone_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic        mem_wen_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic        mem_rsp_valid_i,
   input  logic [63:0] mem_rdata_i,
   output logic        err_o
);

   localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [63:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;
   logic [63:0] rdata_q, rdata_d;
   logic [3:0]  starve_q, starve_d;
   logic        err_q, err_d;
   logic        if_win_s, lsu_win_s;
   logic [63:0] merged_s;

   ysyx_220066_byte_merge u_merge (
      .old_i    (mem_rdata_i),
      .new_i    (wdata_q),
      .mask_i   (wmask_q),
      .merged_o (merged_s)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IF;
         addr_q   <= 64'd0;
         we_q     <= 1'b0;
         wdata_q  <= 64'd0;
         wmask_q  <= 8'd0;
         rdata_q  <= 64'd0;
         starve_q <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         rdata_q  <= rdata_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      rdata_d   = rdata_q;
      starve_d  = starve_q;
      err_d     = err_q;
      if_win_s  = 1'b0;
      lsu_win_s = 1'b0;

      case (state_q)
         IDLE: begin
            // LSU normally wins; IF is forced once it has lost STARVE_MAX times in a row
            if (if_req_i && (!lsu_req_i || starve_q == STARVE_CAP)) begin
               if_win_s = 1'b1;
            end else begin
               lsu_win_s = lsu_req_i;
            end

            if (if_win_s) begin
               owner_d  = OWN_IF;
               addr_d   = if_addr_i;
               we_d     = 1'b0;
               wdata_d  = 64'd0;
               wmask_d  = 8'd0;
               starve_d = 4'd0;
               state_d  = RREQ;
            end else if (lsu_win_s) begin
               owner_d = OWN_LSU;
               addr_d  = lsu_addr_i;
               we_d    = lsu_we_i;
               wdata_d = lsu_wdata_i;
               wmask_d = lsu_wmask_i;
               if (if_req_i && starve_q != 4'hF) begin
                  starve_d = starve_q + 4'd1;
               end else begin
                  starve_d = starve_q;
               end
               if (!lsu_we_i) begin
                  state_d = RREQ;
               end else if (lsu_wmask_i == FULL_MASK) begin
                  state_d = WREQ;
               end else if (lsu_wmask_i == 8'h00) begin
                  state_d = DONE;
               end else begin
                  state_d = RREQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RREQ: begin
            if (mem_req_ready_i) begin
               state_d = RWAIT;
            end else begin
               state_d = RREQ;
            end
         end
         RWAIT: begin
            if (mem_rsp_valid_i && we_q) begin
               wdata_d = merged_s;
               state_d = WREQ;
            end else if (mem_rsp_valid_i) begin
               rdata_d = mem_rdata_i;
               state_d = DONE;
            end else begin
               state_d = RWAIT;
            end
         end
         WREQ: begin
            if (mem_req_ready_i) begin
               state_d = WWAIT;
            end else begin
               state_d = WREQ;
            end
         end
         WWAIT: begin
            if (mem_rsp_valid_i) begin
               state_d = DONE;
            end else begin
               state_d = WWAIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (mem_rsp_valid_i && state_q != RWAIT && state_q != WWAIT) begin
         err_d = 1'b1;
      end else begin
         err_d = err_d;
      end
   end

   assign if_gnt_o        = if_win_s;
   assign lsu_gnt_o       = lsu_win_s;
   assign if_rvalid_o     = (state_q == DONE) && (owner_q == OWN_IF);
   assign lsu_rvalid_o    = (state_q == DONE) && (owner_q == OWN_LSU) && !we_q;
   assign lsu_wdone_o     = (state_q == DONE) && (owner_q == OWN_LSU) && we_q;
   assign if_rdata_o      = rdata_q;
   assign lsu_rdata_o     = rdata_q;
   assign mem_req_valid_o = (state_q == RREQ) || (state_q == WREQ);
   assign mem_wen_o       = (state_q == WREQ);
   assign mem_addr_o      = addr_q & ~64'h7;
   assign mem_wdata_o     = wdata_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Directed bench for the pmem arbiter: a small scripted memory responder and
// hand-computed expectations for reads, stores, arbitration, stalls and reset.
module tb_ysyx_220066_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [63:0] if_rdata;
   logic        lsu_req, lsu_we;
   logic [63:0] lsu_addr, lsu_wdata;
   logic [7:0]  lsu_wmask;
   logic        lsu_gnt, lsu_rvalid, lsu_wdone;
   logic [63:0] lsu_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [63:0] mem_addr, mem_wdata;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   logic        auto_rsp;
   logic [63:0] model_rdata;
   logic        o_if_gnt, o_lsu_gnt, o_if_rv, o_lsu_rv, o_wd, o_valid, o_wen;
   logic [63:0] o_if_rdata, o_lsu_rdata, o_addr;
   logic [63:0] rd_addr, wr_addr, wr_data;
   int          n_rd, n_wr, n_valid, n_ifv, n_lsv, n_wd, n_both;

   always #5 clk = ~clk;

   ysyx_220066_mem_arbiter #(.STARVE_MAX(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .if_req_i        (if_req),
      .if_addr_i       (if_addr),
      .if_gnt_o        (if_gnt),
      .if_rvalid_o     (if_rvalid),
      .if_rdata_o      (if_rdata),
      .lsu_req_i       (lsu_req),
      .lsu_we_i        (lsu_we),
      .lsu_addr_i      (lsu_addr),
      .lsu_wdata_i     (lsu_wdata),
      .lsu_wmask_i     (lsu_wmask),
      .lsu_gnt_o       (lsu_gnt),
      .lsu_rvalid_o    (lsu_rvalid),
      .lsu_rdata_o     (lsu_rdata),
      .lsu_wdone_o     (lsu_wdone),
      .mem_req_valid_o (mem_req_valid),
      .mem_req_ready_i (mem_req_ready),
      .mem_wen_o       (mem_wen),
      .mem_addr_o      (mem_addr),
      .mem_wdata_o     (mem_wdata),
      .mem_rsp_valid_i (mem_rsp_valid),
      .mem_rdata_i     (mem_rdata),
      .err_o           (err)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_rd = 0; n_wr = 0; n_valid = 0; n_ifv = 0; n_lsv = 0; n_wd = 0; n_both = 0;
   endtask

   // Sample the cycle just before the edge, advance one clock, then answer any accepted request.
   task automatic step();
      logic hs;
      #2;
      o_if_gnt    = if_gnt;
      o_lsu_gnt   = lsu_gnt;
      o_if_rv     = if_rvalid;
      o_lsu_rv    = lsu_rvalid;
      o_wd        = lsu_wdone;
      o_valid     = mem_req_valid;
      o_wen       = mem_wen;
      o_addr      = mem_addr;
      o_if_rdata  = if_rdata;
      o_lsu_rdata = lsu_rdata;
      hs = mem_req_valid && mem_req_ready;
      if (mem_req_valid) n_valid++;
      if (hs && mem_wen) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (hs && !mem_wen) begin n_rd++; rd_addr = mem_addr; end
      if (if_rvalid) n_ifv++;
      if (lsu_rvalid) n_lsv++;
      if (lsu_wdone) n_wd++;
      if (if_gnt && lsu_gnt) n_both++;
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         mem_rsp_valid = hs;
         mem_rdata     = hs ? model_rdata : 64'd0;
      end
   endtask

   // Issue one request, drop it on grant, return cycles from grant to the owner's pulse (-1 on timeout).
   task automatic do_txn(input logic use_if, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask, output int lat);
      int k;
      logic started;
      lat = -1; started = 1'b0; k = 0;
      if (use_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_wmask = mask;
      end
      for (int i = 0; i < 40 && lat < 0; i++) begin
         step();
         if (started) begin
            k++;
         end else if ((use_if && o_if_gnt) || (!use_if && o_lsu_gnt)) begin
            started = 1'b1; k = 0; if_req = 1'b0; lsu_req = 1'b0;
         end
         if (started && ((use_if && o_if_rv) || (!use_if && (o_lsu_rv || o_wd)))) lat = k;
      end
      if_req = 1'b0; lsu_req = 1'b0;
   endtask

   initial begin
      int lat;
      int ng;
      logic [9:0] order;

      rst = 1'b1; if_req = 1'b0; if_addr = 64'd0; lsu_req = 1'b0; lsu_we = 1'b0;
      lsu_addr = 64'd0; lsu_wdata = 64'd0; lsu_wmask = 8'd0; mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0; mem_rdata = 64'd0; auto_rsp = 1'b1; model_rdata = 64'd0;
      #1;
      check_val("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      check_val("rst_addr", mem_addr, 64'd0);
      check_val("rst_pulses", {61'd0, if_rvalid, lsu_rvalid, lsu_wdone}, 64'd0);
      check_val("rst_err", {63'd0, err}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: IF read from unaligned address
      clr(); model_rdata = 64'h1111_2222_3333_4444;
      do_txn(1'b1, 1'b0, 64'h8000_0004, 64'd0, 8'h00, lat);
      check_val("if_rd_lat", 64'(lat), 64'd3);
      check_val("if_rd_data", o_if_rdata, 64'h1111_2222_3333_4444);
      check_val("if_rd_addr", rd_addr, 64'h8000_0000);
      check_val("if_rd_nwr", 64'(n_wr), 64'd0);

      // LSU load
      clr(); model_rdata = 64'hDEAD_BEEF_0123_4567;
      do_txn(1'b0, 1'b0, 64'h8000_0108, 64'd0, 8'h00, lat);
      check_val("ld_lat", 64'(lat), 64'd3);
      check_val("ld_data", o_lsu_rdata, 64'hDEAD_BEEF_0123_4567);
      check_val("ld_addr", rd_addr, 64'h8000_0108);

      // 3: byte store through read-modify-write
      clr(); model_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      do_txn(1'b0, 1'b1, 64'h8000_0002, 64'h0000_0000_00AB_0000, 8'h04, lat);
      step();
      check_val("sb_lat", 64'(lat), 64'd5);
      check_val("sb_nrd", 64'(n_rd), 64'd1);
      check_val("sb_nwr", 64'(n_wr), 64'd1);
      check_val("sb_wdata", wr_data, 64'hFFFF_FFFF_FFAB_FFFF);
      check_val("sb_waddr", wr_addr, 64'h8000_0000);
      check_val("sb_nwdone", 64'(n_wd), 64'd1);

      // 4: full store and empty-mask store
      clr(); model_rdata = 64'h5555_5555_5555_5555;
      do_txn(1'b0, 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, lat);
      check_val("sd_lat", 64'(lat), 64'd3);
      check_val("sd_nrd", 64'(n_rd), 64'd0);
      check_val("sd_nwr", 64'(n_wr), 64'd1);
      check_val("sd_wdata", wr_data, 64'h0123_4567_89AB_CDEF);
      clr();
      do_txn(1'b0, 1'b1, 64'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'h00, lat);
      step();
      check_val("s0_lat", 64'(lat), 64'd1);
      check_val("s0_nvalid", 64'(n_valid), 64'd0);
      check_val("s0_nwdone", 64'(n_wd), 64'd1);

      // 2: both requesters held high
      clr(); model_rdata = 64'h0;
      if_req = 1'b1; if_addr = 64'h8000_0040;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0048;
      order = 10'd0; ng = 0;
      for (int i = 0; i < 200 && ng < 10; i++) begin
         step();
         if (o_if_gnt) begin
            order[ng] = 1'b1; ng++;
         end else if (o_lsu_gnt) begin
            ng++;
         end
      end
      if_req = 1'b0; lsu_req = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check_val("arb_ngrants", 64'(ng), 64'd10);
      check_val("arb_order", {54'd0, order}, 64'h210);
      check_val("arb_both", 64'(n_both), 64'd0);

      // 5: memory stalls request for 5 cycles
      clr(); model_rdata = 64'hCAFE_F00D_CAFE_F00D; mem_req_ready = 1'b0;
      if_req = 1'b1; if_addr = 64'h8000_0010;
      step();
      check_val("stall_gnt", {63'd0, o_if_gnt}, 64'd1);
      if_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_val("stall_valid", {63'd0, o_valid}, 64'd1);
         check_val("stall_addr", o_addr, 64'h8000_0010);
         check_val("stall_wen", {63'd0, o_wen}, 64'd0);
      end
      check_val("stall_nrd", 64'(n_rd), 64'd0);
      mem_req_ready = 1'b1;
      lat = -1;
      for (int i = 0; i < 10 && lat < 0; i++) begin
         step();
         if (o_if_rv) lat = i;
      end
      check_val("stall_lat", 64'(lat), 64'd2);
      check_val("stall_data", o_if_rdata, 64'hCAFE_F00D_CAFE_F00D);
      check_val("no_err", {63'd0, err}, 64'd0);

      // 6: reset while waiting for a read response, response arrives afterwards
      auto_rsp = 1'b0; mem_rsp_valid = 1'b0;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0100;
      step();
      check_val("rw_gnt", {63'd0, o_lsu_gnt}, 64'd1);
      lsu_req = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check_val("rw_rst_valid", {63'd0, mem_req_valid}, 64'd0);
      check_val("rw_rst_addr", mem_addr, 64'd0);
      check_val("rw_rst_rdata", lsu_rdata, 64'd0);
      step();
      rst = 1'b0;
      clr();
      mem_rsp_valid = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
      step();
      mem_rsp_valid = 1'b0; mem_rdata = 64'd0;
      step();
      step();
      check_val("rw_err", {63'd0, err}, 64'd1);
      check_val("rw_nrvalid", 64'(n_lsv + n_ifv + n_wd), 64'd0);
      check_val("rw_nvalid", 64'(n_valid), 64'd0);
      check_val("rw_rdata", lsu_rdata, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
